// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit stage (and the receive stage
// on the far end of the link): parity encodings, the TX FSM state type and
// the legal data-bit range with its clamp helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int unsigned MIN_DATA_BIT = 5;
  localparam int unsigned MAX_DATA_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Out-of-range data-bit requests are pulled into MIN_DATA_BIT..MAX_DATA_BIT.
  function automatic logic [3:0] clamp_data_bit(input logic [3:0] raw);
    if (raw < 4'(MIN_DATA_BIT)) return 4'(MIN_DATA_BIT);
    if (raw > 4'(MAX_DATA_BIT)) return 4'(MAX_DATA_BIT);
    return raw;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO placed in front of the UART transmit FSM (only built when
// UART_TX_FIFO_EN is defined in uart_transmitter).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_push, i_push_data write request and data (ignored when full)
//   i_pop               read request (ignored when empty)
//   o_pop_data          head entry, valid while !o_empty
//   o_full, o_empty     occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push && !o_full) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (i_pop && !o_empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: one line bit per i_u_clk cycle (bit-rate clock).
// Frame: start(0), N data bits LSB first, optional parity, S stop bits(1).
// Ports:
//   i_u_clk, i_u_rst   bit-rate clock, asynchronous active-high reset
//   i_uart_tx_data     byte to send (only the low N bits are used)
//   i_uart_tx_valid    data valid; accepted when o_uart_tx_ready is high
//   o_uart_tx_ready    transmitter (or its FIFO) can take a byte this cycle
//   i_data_bit         data bits per frame, clamped to 5..8
//   i_stop_bit         0/1 -> one stop bit, 2/3 -> two stop bits
//   i_check_bit        0 none, 1 odd, 2 even, 3 none
//   o_uart_tx          registered serial line, idle high
//   o_uart_tx_busy     a frame is in progress
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in
// front of the FSM (ready then means "FIFO not full").
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_u_clk,
  input  logic              i_u_rst,
  input  logic [DATA_W-1:0] i_uart_tx_data,
  input  logic              i_uart_tx_valid,
  output logic              o_uart_tx_ready,
  input  logic [3:0]        i_data_bit,
  input  logic [1:0]        i_stop_bit,
  input  logic [1:0]        i_check_bit,
  output logic              o_uart_tx,
  output logic              o_uart_tx_busy
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              par_acc_q, par_acc_d;
  logic              tx_q, tx_d;

  logic              last_stop;
  logic              fsm_ready;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              take;

  assign last_stop = (state_q == STOP) && (stop_cnt_q == two_stop_q);
  assign fsm_ready = (state_q == IDLE) || last_stop;
  assign take      = fsm_ready && src_valid;

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_u_clk),
    .i_rst      (i_u_rst),
    .i_push     (i_uart_tx_valid && o_uart_tx_ready),
    .i_push_data(i_uart_tx_data),
    .i_pop      (take),
    .o_pop_data (src_data),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

  assign src_valid       = !fifo_empty;
  assign o_uart_tx_ready = !i_u_rst && !fifo_full;
`else
  assign src_valid       = i_uart_tx_valid;
  assign src_data        = i_uart_tx_data;
  assign o_uart_tx_ready = !i_u_rst && fsm_ready;
`endif

  assign o_uart_tx      = tx_q;
  assign o_uart_tx_busy = (state_q != IDLE);

  // tx_d is the line value for the state being entered, so the line stays
  // registered while still starting the start bit one cycle after acceptance.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_acc_d  = par_acc_q;
    tx_d       = tx_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end
      START: begin
        state_d   = DATA;
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        par_acc_d = shift_q[0];
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == nbits_q - 4'd1) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_acc_q ^ par_odd_q;
          end else begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          par_acc_d = par_acc_q ^ shift_q[0];
        end
      end
      PARITY: begin
        state_d    = STOP;
        tx_d       = 1'b1;
        stop_cnt_d = 1'b0;
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_stop) state_d = IDLE;
        else           stop_cnt_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // take is only possible in IDLE or the last stop cycle, so loading a new
    // frame here overrides whatever those two branches chose.
    if (take) begin
      state_d    = START;
      tx_d       = 1'b0;
      shift_d    = src_data;
      nbits_d    = clamp_data_bit(i_data_bit);
      two_stop_d = (i_stop_bit >= 2'd2);
      par_en_d   = (i_check_bit == PAR_ODD) || (i_check_bit == PAR_EVEN);
      par_odd_d  = (i_check_bit == PAR_ODD);
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      par_acc_d  = 1'b0;
    end
  end

  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_acc_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_acc_q  <= par_acc_d;
      tx_q       <= tx_d;
    end
  end

endmodule
